// File: rtl/serial_parity_checker.sv
// Serial parity checker: groups x_valid-qualified bits into frames of FRAME_LEN
// data bits plus one parity bit, checks parity (even/odd) and counts errors.
// Latency: parity is combinational (Mealy); frame_done/parity_err/err_count update
// on the clock edge that accepts the parity bit. No backpressure: x_valid=0 stalls.
//
// Ports:
//   clk        - system clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   x, x_valid - serial data bit and its qualifier
//   odd_mode   - 1=odd parity, 0=even; latched on the first bit of each frame
//   abort      - synchronous frame abort, overrides x_valid
//   parity     - running expected parity (combinational, forced 0 in reset)
//   busy       - a frame is in progress
//   bit_cnt    - data bits accepted in the current frame
//   frame_done - one-cycle pulse after the parity bit has been checked
//   parity_err - one-cycle pulse alongside frame_done when parity mismatched
//   err_count  - saturating count of frames with parity errors
//
// FRAME_LEN must be in 2..256; a frame always spends at least one cycle in DATA.

module serial_parity_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8,
  localparam int BW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             odd_mode,
  input  logic             abort,
  output logic             parity,
  output logic             busy,
  output logic [BW-1:0]    bit_cnt,
  output logic             frame_done,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_e;

  // bit_cnt value at which the incoming data bit is the last one of the frame
  localparam logic [BW-1:0] LAST_DATA = BW'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             parity_raw;
  logic             x_bit;

  // x only contributes when qualified
  assign x_bit = x_valid & x;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (x_valid) begin
          acc_d     = x;
          mode_d    = odd_mode;
          bit_cnt_d = BW'(1);
          state_d   = DATA;
        end
      end
      DATA: begin
        if (x_valid) begin
          acc_d     = acc_q ^ x;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_DATA) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (x_valid) begin
          done_d    = 1'b1;
          err_d     = (x != (acc_q ^ mode_q));
          state_d   = IDLE;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        acc_d     = 1'b0;
        bit_cnt_d = '0;
      end
    endcase

    // Abort wins over any bit accepted this cycle; the latched mode is
    // irrelevant once back in IDLE, so it simply holds.
    if (abort) begin
      state_d   = IDLE;
      acc_d     = 1'b0;
      mode_d    = mode_q;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end

    // Counter steps together with the registered error pulse, holding at max
    if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      mode_q    <= 1'b0;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Mealy parity: in IDLE/DATA it already folds in the bit on the wire so the
  // front-end sees the parity including the current bit; in PARITY it is the
  // expected parity bit for the frame.
  always_comb begin
    parity_raw = 1'b0;
    case (state_q)
      IDLE:    parity_raw = odd_mode ^ x_bit;
      DATA:    parity_raw = acc_q ^ mode_q ^ x_bit;
      PARITY:  parity_raw = acc_q ^ mode_q;
      default: parity_raw = 1'b0;
    endcase
  end

  // Reset gates the combinational output so every output reads 0 immediately
  assign parity     = parity_raw & reset;
  assign busy       = (state_q != IDLE);
  assign bit_cnt    = bit_cnt_q;
  assign frame_done = done_q;
  assign parity_err = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
module tb_serial_parity_checker;

  localparam int FL = 8;
  localparam int CW = 2;
  localparam int BW = $clog2(FL + 1);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          x, x_valid, odd_mode, abort;
  logic          parity, busy, frame_done, parity_err;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] err_count;

  serial_parity_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .x_valid    (x_valid),
    .odd_mode   (odd_mode),
    .abort      (abort),
    .parity     (parity),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done),
    .parity_err (parity_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit err;
    int cnt;
  } exp_t;

  // Scoreboard of expected frame results, filled by the driver, drained by the monitor
  exp_t sb_q[$];

  // Reference model: the data bits of the open frame, its latched mode, error total
  bit m_bits[$];
  bit m_mode;
  int m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit data_parity();
    int ones = 0;
    foreach (m_bits[i]) ones += int'(m_bits[i]);
    return ones % 2 == 1;
  endfunction

  // One clock cycle: drive at negedge, check combinational/state outputs,
  // then advance the model at the posedge.
  task automatic step(input bit xv, input bit xb, input bit om, input bit ab);
    bit exp_par;
    @(negedge clk);
    x_valid  = xv;
    x        = xb;
    odd_mode = om;
    abort    = ab;
    #1;
    if (m_bits.size() == 0)      exp_par = om ^ (xv & xb);
    else if (m_bits.size() < FL) exp_par = data_parity() ^ m_mode ^ (xv & xb);
    else                         exp_par = data_parity() ^ m_mode;
    check("busy", 32'(busy), 32'(m_bits.size() != 0));
    check("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
    check("parity", 32'(parity), 32'(exp_par));
    @(posedge clk);
    if (ab) begin
      m_bits.delete();
    end else if (xv) begin
      if (m_bits.size() < FL) begin
        if (m_bits.size() == 0) m_mode = om;
        m_bits.push_back(xb);
      end else begin
        exp_t e;
        e.err = (xb != (data_parity() ^ m_mode));
        if (e.err && m_err < CNT_MAX) m_err++;
        e.cnt = m_err;
        sb_q.push_back(e);
        m_bits.delete();
      end
    end
  endtask

  task automatic send_frame(input bit [FL-1:0] d, input bit pbit, input bit om);
    for (int i = FL - 1; i >= 0; i--) step(1'b1, d[i], om, 1'b0);
    step(1'b1, pbit, om, 1'b0);
  endtask

  // Monitor: every registered frame result is matched against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (frame_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got 1 expected 0 at %0t", $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("parity_err", 32'(parity_err), 32'(e.err));
          check("err_count", 32'(err_count), 32'(e.cnt));
        end
      end else begin
        check("stray_parity_err", 32'(parity_err), 32'(0));
      end
    end
  end

  localparam bit [FL-1:0] PAT = 8'b1011_0010;

  initial begin
    reset    = 1'b0;
    x        = 1'b1;
    x_valid  = 1'b1;
    odd_mode = 1'b1;
    abort    = 1'b0;
    m_mode   = 1'b0;
    m_err    = 0;
    #1;
    check("rst_parity", 32'(parity), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_bit_cnt", 32'(bit_cnt), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_err_count", 32'(err_count), 32'(0));
    repeat (2) @(negedge clk);
    x_valid = 1'b0;
    reset   = 1'b1;

    // Even mode, four ones, parity bit 0: clean
    send_frame(PAT, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // Odd mode, parity bit 0: error; then parity bit 1: clean
    send_frame(PAT, 1'b0, 1'b1);
    send_frame(PAT, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped frame with odd_mode toggling mid-frame (must not matter)
    for (int i = FL - 1; i >= FL - 3; i--) step(1'b1, PAT[i], 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = FL - 4; i >= 0; i--) step(1'b1, PAT[i], 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Abort after 5 data bits, with a valid bit in the same cycle
    for (int i = FL - 1; i >= FL - 5; i--) step(1'b1, PAT[i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(PAT, 1'b1, 1'b1);

    // Abort arriving with the parity bit: no result for that frame
    send_frame(PAT, 1'b1, 1'b0);
    for (int i = FL - 1; i >= 0; i--) step(1'b1, PAT[i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after 4 bits, mid-cycle, with live inputs
    for (int i = FL - 1; i >= FL - 4; i--) step(1'b1, PAT[i], 1'b1, 1'b0);
    @(negedge clk);
    x_valid  = 1'b1;
    x        = 1'b1;
    odd_mode = 1'b1;
    abort    = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_parity", 32'(parity), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_bit_cnt", 32'(bit_cnt), 32'(0));
    check("midrst_frame_done", 32'(frame_done), 32'(0));
    check("midrst_parity_err", 32'(parity_err), 32'(0));
    check("midrst_err_count", 32'(err_count), 32'(0));
    m_bits.delete();
    sb_q.delete();
    m_err = 0;
    @(negedge clk);
    x_valid = 1'b0;
    reset   = 1'b1;

    // Five back-to-back erroneous frames: err_count 1,2,3,3,3
    for (int f = 0; f < 5; f++) send_frame(PAT, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 40) == 0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Parametrised successor to the single-bit Mealy parity FSM.
- Accepts a serial bit stream qualified by x_valid and groups it into frames of FRAME_LEN data bits, each followed by one received parity bit.
- Provides a Mealy running-parity output, checks each received parity bit against the expected value in even or odd mode, and flags and counts errors.
- Sits between a serial receiver front-end and frame-level control logic.

Parameters:
FRAME_LEN, 8, data bits per frame (legal range 2..256)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
x  input  1  serial data bit; ignored when x_valid=0
x_valid  input  1  x carries a bit this cycle
odd_mode  input  1  1=odd parity, 0=even; sampled only on the first bit of a frame
abort  input  1  synchronous frame abort
parity  output  1  Mealy running expected-parity output (combinational)
busy  output  1  frame in progress (state != IDLE)
bit_cnt  output  $clog2(FRAME_LEN+1)  data bits accepted in the current frame
frame_done  output  1  one-cycle pulse after the parity bit is checked
parity_err  output  1  one-cycle pulse coincident with frame_done on mismatch
err_count  output  CNT_W  saturating count of frames with parity errors

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; acc=0; mode_l=0; bit_cnt=0.
  - frame_done=0, parity_err=0, err_count=0.
  - parity is forced to 0 while reset is low.
- States: IDLE, DATA, PARITY.
- IDLE:
  - On x_valid=1: acc<=x; mode_l<=odd_mode; bit_cnt<=1; go to DATA.
  - If FRAME_LEN==1 were allowed this would go straight to PARITY; FRAME_LEN>=2 is enforced.
- DATA:
  - On x_valid=1: acc<=acc^x; bit_cnt<=bit_cnt+1.
  - When bit_cnt+1==FRAME_LEN, go to PARITY.
  - x_valid=0 cycles stall the frame with no timeout; all state is held.
- PARITY:
  - On x_valid=1: frame_done<=1 next cycle; parity_err<=(x != (acc^mode_l)).
  - Then: return to IDLE; acc<=0; bit_cnt<=0.
- parity (Mealy, combinational):
  - IDLE: odd_mode ^ (x_valid & x).
  - DATA: acc ^ mode_l ^ (x_valid & x).
  - PARITY: acc ^ mode_l, i.e. the expected parity bit for the current frame.
- frame_done and parity_err are registered one-cycle pulses; at most one pair per frame.
- err_count:
  - Increments in the same cycle parity_err is registered high.
  - Saturates at 2^CNT_W-1; no wrap.
- abort=1 (any state):
  - Next cycle: state=IDLE, acc=0, bit_cnt=0; no frame_done or parity_err.
  - abort has priority over x_valid in the same cycle.
  - err_count is unaffected.
- Back-to-back frames: a valid bit in the cycle after the parity bit starts a new frame from IDLE with no bubble required.
- odd_mode changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame discards the frame and clears err_count.

Test Plan:
- Even mode, FRAME_LEN=8:
  - Send 1,0,1,1,0,0,1,0 (four ones) then parity bit 0 → parity=0 during the PARITY state.
  - frame_done pulses 1 cycle after the parity bit; parity_err=0; err_count=0.
- Odd mode, same data, parity bit 0:
  - parity=1 in the PARITY state; frame_done=1 and parity_err=1 together; err_count=1.
  - Repeat with parity bit 1 → no error; err_count stays 1.
- Gapped input:
  - Insert x_valid=0 for 3 cycles between bits 3 and 4 → bit_cnt holds at 3 and busy stays 1.
  - Result is identical to the ungapped frame.
- Abort:
  - Assert abort after 5 data bits → next cycle busy=0 and bit_cnt=0; no frame_done.
  - A following full frame checks correctly.
- Saturation, CNT_W=2: send 5 erroneous frames → err_count sequence 1,2,3,3,3.
- Reset mid-frame:
  - Drop reset after 4 bits → all outputs 0 immediately, without waiting for clk.
  - After release, the first valid bit starts a fresh frame (bit_cnt=1).
  - Back-to-back frames with no idle cycles each produce exactly one frame_done.
